// File: rtl/prog_load_pkg.sv
// Shared types and sizes for the program loader.
// State encoding plus default image geometry.
package prog_load_pkg;

  localparam int WORD_W = 8;
  localparam int DEPTH  = 8;

  typedef enum logic [1:0] {
    ARM,
    LOAD,
    RUN
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer and debouncer.
// Emits a debounced level and a one-cycle rise strobe.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Adopt the new level only after it stays different long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= sync2;
        rise  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_load_ctrl.sv
// Push-button program loader for the core.
// Collects switch words into an image, then releases the CPU.
module prog_load_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WORD_W = prog_load_pkg::WORD_W,
  parameter int DEPTH  = prog_load_pkg::DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WORD_W-1:0]          input_val,
  input  logic                       but_inp,
  input  logic                       load_mode,
  output logic [WORD_W*DEPTH-1:0]    instr_mem,
  output logic [$clog2(DEPTH+1)-1:0] word_cnt,
  output logic                       wr_pulse,
  output logic                       load_done,
  output logic                       cpu_rst
);

  import prog_load_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  state_t             state;
  state_t             state_n;
  logic               level;
  logic               rise;
  logic               lm_q;
  logic               commit;
  logic [IDX_W-1:0]   slot;

  assign slot = word_cnt[IDX_W-1:0];

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk  (clk),
    .reset(reset),
    .raw  (but_inp),
    .level(level),
    .rise (rise)
  );

  // Next state and write-commit decision.
  always_comb begin
    state_n = state;
    commit  = 1'b0;
    unique case (state)
      ARM: begin
        if (!level) state_n = load_mode ? LOAD : RUN;
      end
      LOAD: begin
        commit = rise && (word_cnt != FULL);
        if (word_cnt == FULL || !load_mode) state_n = RUN;
      end
      RUN: begin
        if (load_mode && !lm_q) state_n = ARM;
      end
      default: state_n = ARM;
    endcase
  end

  // State register with registered CPU control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARM;
      lm_q      <= 1'b0;
      load_done <= 1'b0;
      cpu_rst   <= 1'b1;
    end else begin
      state     <= state_n;
      lm_q      <= load_mode;
      load_done <= (state_n == RUN);
      cpu_rst   <= (state_n != RUN);
    end
  end

  // Image register, word counter and write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_mem <= '0;
      word_cnt  <= '0;
      wr_pulse  <= 1'b0;
    end else begin
      wr_pulse <= commit;
      if (commit) begin
        instr_mem[slot*WORD_W +: WORD_W] <= input_val;
        word_cnt <= word_cnt + 1'b1;
      end else if (state == RUN && state_n == ARM) begin
        word_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/prog_load_ctrl.md
PROG_LOAD_CTRL -- requirements
Module: prog_load_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed before the debounced button level changes; legal range 1..65535.
REQ-002 Parameter WORD_W, default 8: instruction word width.
REQ-003 Parameter DEPTH, default 8: number of instruction slots.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 input_val  input  8  switch value for the instruction being entered; sampled on the write-commit cycle.
REQ-007 but_inp  input  1  raw, asynchronous, bouncing "enter" push-button.
REQ-008 load_mode  input  1  1 = program-entry mode requested, 0 = run mode.
REQ-009 instr_mem  output  64  packed program image: slot k at bits [8k+7:8k].
REQ-010 word_cnt  output  4  number of words written since entering LOAD (0..8).
REQ-011 wr_pulse  output  1  one-cycle strobe on each write commit.
REQ-012 load_done  output  1  1 while in RUN state.
REQ-013 cpu_rst  output  1  active-high hold reset to the 5-stage core; 1 in ARM/LOAD, 0 in RUN.

Function
REQ-014 but_inp SHALL pass through a 2-flop synchronizer before any use.
REQ-015 The debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any reversion clears the count.
REQ-016 A press SHALL be a 0->1 transition of the debounced level; one press yields exactly one write, whatever the hold time.
REQ-017 Press-to-commit latency SHALL be exactly DEBOUNCE_CYCLES+3 rising edges after but_inp rises, given a clean input.
REQ-018 States SHALL be ARM, LOAD, RUN.
REQ-019 ARM: wait for debounced level 0; then go to LOAD if load_mode=1, else go to RUN. Presses are ignored in ARM.
REQ-020 LOAD: on press, write input_val to slot word_cnt[2:0], increment word_cnt, and pulse wr_pulse for that one cycle.
REQ-021 LOAD: go to RUN on the cycle after the 8th commit (word_cnt=8), or on the cycle after load_mode=0 is seen.
REQ-022 If a commit and load_mode=0 occur in the same cycle, the write SHALL complete first; the state is RUN on the next cycle.
REQ-023 Unwritten slots SHALL keep their previous contents (0 after reset = NOP).
REQ-024 RUN: presses SHALL be ignored and instr_mem SHALL hold constant.
REQ-025 RUN: a 0->1 transition of load_mode SHALL return the block to ARM with word_cnt cleared; instr_mem is retained until slots are overwritten.
REQ-026 word_cnt SHALL saturate at 8; no write SHALL occur while word_cnt=8.
REQ-027 cpu_rst and load_done SHALL be registered, glitch-free, and SHALL change on the same edge as the state.

Reset
REQ-028 Reset SHALL set: state ARM, instr_mem 0, word_cnt 0, wr_pulse 0, load_done 0, cpu_rst 1, synchronizer and debounce logic 0.
REQ-029 Reset asserted mid-LOAD SHALL discard all entered words on the next edge; it overrides any same-cycle commit.

Structure
REQ-030 Package prog_load_pkg SHALL hold the state enum (ARM, LOAD, RUN), WORD_W=8 and DEPTH=8.
REQ-031 Synchronizer plus debounce SHALL be one sub-module, btn_debounce (ports: clk, reset, raw, level, rise).
REQ-032 The FSM and the memory-image register SHALL be in prog_load_ctrl.

Verification
REQ-033 Reset, load_mode=1, then 8 clean presses with input_val 0x88,0x89,0x8A,0x8C,0x90,0xA8,0x89,0xFF -> instr_mem=0xFF89A8908C8A8988, word_cnt=8, then load_done=1 and cpu_rst=0.
REQ-034 With DEBOUNCE_CYCLES=4: a but_inp glitch high for 3 cycles -> no wr_pulse; a clean rise -> wr_pulse exactly 7 edges later.
REQ-035 but_inp bouncing 0/1 each cycle for 10 cycles, then held high for 50 cycles -> exactly one write.
REQ-036 Three writes (0x11,0x22,0x33), then load_mode=0 -> RUN with instr_mem=0x0000000000332211; further presses -> no change.
REQ-037 Reset asserted after 5 writes -> all outputs at reset values on the next edge; a following load sequence starts at slot 0.
REQ-038 In RUN, toggle load_mode 0->1 while the button is held -> stays in ARM until release; the next press writes slot 0, and the other slots keep their old values.
